mcu_spi_tx: RTL and testbench
=============================

// Module: mcu_spi_tx
// PURPOSE
//  Transmit side of the MCU SPI link. Core logic queues 24-bit response frames {cmd,addr,data};
//  each frame is shifted out MSB-first on MCU_MISO while the MCU clocks a 24-bit transaction
//  (SPI mode 0, MCU_SS low per frame). Sits beside mcu and carries core->MCU traffic
//  (cart size, status, debug words). Runs entirely in the CLK domain; SCK/SS are oversampled.
// PARAMETERS
//  FIFO_DEPTH   4      response FIFO entries; power of two, >=2
//  SYNC_STAGES  2      synchronizer flops on MCU_SCK / MCU_SS, >=2
//  IDLE_FRAME   24'h0  frame sent when FIFO is empty
// PORTS
//  CLK        in   1   core clock (56 MHz)
//  RESET      in   1   synchronous, active-high
//  MCU_SCK    in   1   SPI clock from MCU, async, <= CLK/8
//  MCU_SS     in   1   SPI select from MCU, active-low, async
//  MCU_MISO   out  1   serial data to MCU
//  TX_CMD     in   8   frame byte 0 (sent first)
//  TX_ADDR    in   8   frame byte 1
//  TX_DATA    in   8   frame byte 2
//  TX_WR      in   1   1-cycle push strobe
//  TX_FULL    out  1   FIFO full
//  TX_EMPTY   out  1   FIFO empty
//  TX_LEVEL   out  clog2(FIFO_DEPTH)+1   entries queued
//  TX_OVF     out  1   1-cycle pulse: push dropped because FIFO full
//  FRAME_DONE out  1   1-cycle pulse: 24th bit clocked by MCU
// BEHAVIOUR
//  - Reset: FIFO empty, TX_EMPTY=1, TX_FULL=0, TX_LEVEL=0, MCU_MISO=0, TX_OVF=0, FRAME_DONE=0, state IDLE.
//  - Synchronizers reset to SCK=0, SS=1. Edges are detected on synchronized signals; total
//    latency pin->edge = SYNC_STAGES+1 CLK.
//  - States: IDLE (SS high) -> SHIFT on SS fall: shifter <= FIFO head (IDLE_FRAME if empty),
//    bitcnt<=0, MISO<=shifter[23] in the same cycle. MCU must allow >=4 CLK from SS fall to first SCK rise.
//  - SHIFT: SCK rise -> bitcnt++; SCK fall -> shift left, MISO<=next bit. On the 24th SCK rise
//    -> DONE: pulse FRAME_DONE; pop head if the frame was a FIFO entry (not IDLE_FRAME).
//  - DONE: MISO held 0; further SCK edges ignored until SS rises -> IDLE.
//  - SS rise in SHIFT before 24 bits (abort): no pop, head is resent in full on next frame; -> IDLE.
//  - FIFO content is snapshotted at SS fall; a push during a frame never alters the frame in flight.
//  - Push: TX_WR && !TX_FULL writes tail. TX_WR && TX_FULL: dropped, TX_OVF pulses.
//  - Push and pop in same cycle: both take effect, level unchanged; when full, push is accepted
//    (pop frees the slot in that cycle).
//  - Pointers are log2(DEPTH) bits and wrap naturally; level counter is one bit wider.
//  - TX_FULL/TX_EMPTY/TX_LEVEL are registered, valid the cycle after push/pop.
//  - MISO in IDLE = 0. RESET mid-frame: all state cleared, queued entries lost, MISO=0 next cycle.
// STRUCTURE
//  - Shared package/header: SPI_FRAME_W=24, IDLE_FRAME value, response command codes
//    (CMD_STATUS, CMD_CART_SIZE, CMD_DEBUG) shared with mcu receive path.
//  - Sub-module spi_tx_fifo (sync FIFO, 24-bit wide, DEPTH param, full/empty/level/ovf).
//  - Top: synchronizers, edge detect, 3-state FSM (IDLE/SHIFT/DONE), 24-bit shifter, 5-bit bitcnt.
// TESTING
//  - Push {A5,3C,0F}, MCU clocks 24 bits -> MISO reads 0xA53C0F, FRAME_DONE once, TX_EMPTY=1.
//  - Empty FIFO, MCU clocks frame -> reads 0x000000, no pop, TX_LEVEL stays 0.
//  - Push 5 frames into depth 4 -> 5th gives TX_OVF pulse, TX_LEVEL=4, TX_FULL=1; 4 frames read in order.
//  - Push 0x112233, SS rises after 10 bits, new frame -> full 0x112233 resent, then popped.
//  - FIFO full, push coincident with 24th SCK rise -> push accepted, TX_LEVEL stays 4, no TX_OVF.
//  - RESET asserted at bit 12 -> MISO=0, TX_LEVEL=0; next frame returns 0x000000.

Source files
------------

// File: rtl/mcu_spi_tx_pkg.sv
// Shared definitions for the MCU SPI link (transmit side and mcu receive path).
//   SPI_FRAME_W        : bits per SPI transaction
//   IDLE_FRAME_DEFAULT : frame returned to the MCU when nothing is queued
//   CMD_*              : response command codes carried in frame byte 0
//   tx_state_t         : transmit FSM states
package mcu_spi_tx_pkg;

   localparam int SPI_FRAME_W = 24;

   localparam logic [SPI_FRAME_W-1:0] IDLE_FRAME_DEFAULT = 24'h000000;

   localparam logic [7:0] CMD_STATUS    = 8'h01;
   localparam logic [7:0] CMD_CART_SIZE = 8'h02;
   localparam logic [7:0] CMD_DEBUG     = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/mcu_spi_tx_fifo.sv
// Synchronous response FIFO, one frame wide.
//   clk, srst      : clock, synchronous active-high reset
//   wr, wr_data    : push strobe and frame
//   rd             : pop strobe (only asserted by the caller when not empty)
//   rd_data        : current head frame (combinational read of a small array)
//   full, empty    : registered status
//   level          : registered entry count, one bit wider than the pointers
//   ovf            : 1-cycle pulse when a push was dropped
module mcu_spi_tx_fifo
   import mcu_spi_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       wr,
   input  logic [SPI_FRAME_W-1:0]     wr_data,
   input  logic                       rd,
   output logic [SPI_FRAME_W-1:0]     rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [SPI_FRAME_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [LVL_W-1:0]       level_reg;
   logic [LVL_W-1:0]       level_next;
   logic                   full_reg;
   logic                   empty_reg;
   logic                   ovf_reg;
   logic                   push_ok;
   logic                   pop_ok;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
   assign pop_ok     = rd && !empty_reg;
   assign push_ok    = wr && (!full_reg || pop_ok);
   assign level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         ovf_reg    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         level_reg <= level_next;
         full_reg  <= (level_next == LVL_W'(DEPTH));
         empty_reg <= (level_next == '0);
         ovf_reg   <= wr && !push_ok;
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign full    = full_reg;
   assign empty   = empty_reg;
   assign level   = level_reg;
   assign ovf     = ovf_reg;

endmodule

// File: rtl/mcu_spi_tx.sv
// Transmit side of the MCU SPI link (SPI mode 0, MSB first, 24-bit frames).
//   CLK, RESET            : core clock, synchronous active-high reset
//   MCU_SCK, MCU_SS       : asynchronous SPI clock / active-low select, oversampled here
//   MCU_MISO              : serial data to the MCU
//   TX_CMD/ADDR/DATA, TX_WR : frame push interface
//   TX_FULL, TX_EMPTY, TX_LEVEL, TX_OVF : FIFO status
//   FRAME_DONE            : 1-cycle pulse when the 24th bit has been clocked
module mcu_spi_tx
   import mcu_spi_tx_pkg::*;
#(
   parameter int                     FIFO_DEPTH  = 4,
   parameter int                     SYNC_STAGES = 2,
   parameter logic [SPI_FRAME_W-1:0] IDLE_FRAME  = IDLE_FRAME_DEFAULT
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          MCU_SCK,
   input  logic                          MCU_SS,
   output logic                          MCU_MISO,
   input  logic [7:0]                    TX_CMD,
   input  logic [7:0]                    TX_ADDR,
   input  logic [7:0]                    TX_DATA,
   input  logic                          TX_WR,
   output logic                          TX_FULL,
   output logic                          TX_EMPTY,
   output logic [$clog2(FIFO_DEPTH):0]   TX_LEVEL,
   output logic                          TX_OVF,
   output logic                          FRAME_DONE
);

   logic [SYNC_STAGES-1:0] sck_sync_reg;
   logic [SYNC_STAGES-1:0] ss_sync_reg;
   logic                   sck_prev_reg;
   logic                   ss_prev_reg;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   ss_fall;
   logic                   ss_rise;

   tx_state_t              state_reg, state_next;
   logic [SPI_FRAME_W-1:0] shifter_reg, shifter_next;
   logic [4:0]             bitcnt_reg, bitcnt_next;
   logic                   from_fifo_reg, from_fifo_next;
   logic                   frame_done_reg, frame_done_next;
   logic                   pop;
   logic [SPI_FRAME_W-1:0] head;

   // Synchronizers idle at SCK=0 / SS=1 so reset never looks like an edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sck_sync_reg <= '0;
         ss_sync_reg  <= '1;
         sck_prev_reg <= 1'b0;
         ss_prev_reg  <= 1'b1;
      end else begin
         sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], MCU_SCK};
         ss_sync_reg  <= {ss_sync_reg[SYNC_STAGES-2:0], MCU_SS};
         sck_prev_reg <= sck_sync_reg[SYNC_STAGES-1];
         ss_prev_reg  <= ss_sync_reg[SYNC_STAGES-1];
      end
   end

   assign sck_rise =  sck_sync_reg[SYNC_STAGES-1] && !sck_prev_reg;
   assign sck_fall = !sck_sync_reg[SYNC_STAGES-1] &&  sck_prev_reg;
   assign ss_fall  = !ss_sync_reg[SYNC_STAGES-1]  &&  ss_prev_reg;
   assign ss_rise  =  ss_sync_reg[SYNC_STAGES-1]  && !ss_prev_reg;

   mcu_spi_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .srst    (RESET),
      .wr      (TX_WR),
      .wr_data ({TX_CMD, TX_ADDR, TX_DATA}),
      .rd      (pop),
      .rd_data (head),
      .full    (TX_FULL),
      .empty   (TX_EMPTY),
      .level   (TX_LEVEL),
      .ovf     (TX_OVF)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg      <= ST_IDLE;
         shifter_reg    <= '0;
         bitcnt_reg     <= '0;
         from_fifo_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shifter_reg    <= shifter_next;
         bitcnt_reg     <= bitcnt_next;
         from_fifo_reg  <= from_fifo_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // MISO is the shifter MSB; the shifter is cleared outside SHIFT so MISO idles low.
   always_comb begin
      state_next      = state_reg;
      shifter_next    = shifter_reg;
      bitcnt_next     = bitcnt_reg;
      from_fifo_next  = from_fifo_reg;
      frame_done_next = 1'b0;
      pop             = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            shifter_next = '0;
            if (ss_fall) begin
               // Snapshot the head now; later pushes only touch the tail.
               shifter_next   = TX_EMPTY ? IDLE_FRAME : head;
               from_fifo_next = !TX_EMPTY;
               bitcnt_next    = '0;
               state_next     = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (ss_rise) begin
               // Aborted frame: head stays queued and is resent in full.
               shifter_next = '0;
               state_next   = ST_IDLE;
            end else if (sck_rise) begin
               bitcnt_next = bitcnt_reg + 5'd1;
               if (bitcnt_reg == 5'(SPI_FRAME_W - 1)) begin
                  frame_done_next = 1'b1;
                  pop             = from_fifo_reg;
                  shifter_next    = '0;
                  state_next      = ST_DONE;
               end
            end else if (sck_fall) begin
               shifter_next = {shifter_reg[SPI_FRAME_W-2:0], 1'b0};
            end
         end
         ST_DONE: begin
            shifter_next = '0;
            if (ss_rise) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            shifter_next = '0;
            state_next   = ST_IDLE;
         end
      endcase
   end

   assign MCU_MISO   = shifter_reg[SPI_FRAME_W-1];
   assign FRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_mcu_spi_tx.sv
// Directed bench for mcu_spi_tx: an MCU model clocks frames at CLK/8 and
// samples MISO just before each SCK rise; results are compared against
// hand-computed frames and FIFO status values.
module tb_mcu_spi_tx;
   import mcu_spi_tx_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mcu_sck = 1'b0;
   logic        mcu_ss = 1'b1;
   logic        mcu_miso;
   logic [7:0]  tx_cmd = 8'h00;
   logic [7:0]  tx_addr = 8'h00;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_wr = 1'b0;
   logic        tx_full;
   logic        tx_empty;
   logic [2:0]  tx_level;
   logic        tx_ovf;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int ovf_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   mcu_spi_tx #(
      .FIFO_DEPTH  (4),
      .SYNC_STAGES (2),
      .IDLE_FRAME  (24'h000000)
   ) dut (
      .CLK        (clk),
      .RESET      (reset),
      .MCU_SCK    (mcu_sck),
      .MCU_SS     (mcu_ss),
      .MCU_MISO   (mcu_miso),
      .TX_CMD     (tx_cmd),
      .TX_ADDR    (tx_addr),
      .TX_DATA    (tx_data),
      .TX_WR      (tx_wr),
      .TX_FULL    (tx_full),
      .TX_EMPTY   (tx_empty),
      .TX_LEVEL   (tx_level),
      .TX_OVF     (tx_ovf),
      .FRAME_DONE (frame_done)
   );

   // Pulse counters; tests compare deltas around a transaction.
   always @(negedge clk) begin
      if (tx_ovf)     ovf_cnt++;
      if (frame_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic push(input logic [23:0] f);
      {tx_cmd, tx_addr, tx_data} = f;
      tx_wr = 1'b1;
      ticks(1);
      tx_wr = 1'b0;
      ticks(1);
   endtask

   // MCU transaction of nbits bits; optionally pushes push_val so that the
   // push reaches the DUT in the same cycle the last SCK rise is detected
   // (pin->edge latency is SYNC_STAGES+1 = 3 CLK).
   task automatic mcu_frame(input int nbits, input bit push_last,
                            input logic [23:0] push_val, output logic [23:0] rx);
      rx = '0;
      mcu_ss = 1'b0;
      ticks(4);
      for (int b = 0; b < nbits; b++) begin
         rx = {rx[22:0], mcu_miso};
         mcu_sck = 1'b1;
         if (push_last && b == nbits - 1) begin
            ticks(2);
            {tx_cmd, tx_addr, tx_data} = push_val;
            tx_wr = 1'b1;
            ticks(1);
            tx_wr = 1'b0;
            ticks(1);
         end else begin
            ticks(4);
         end
         mcu_sck = 1'b0;
         ticks(4);
      end
      mcu_ss = 1'b1;
      ticks(6);
   endtask

   initial begin
      logic [23:0] rx;
      logic [23:0] exp_q [$];
      int d0;
      int o0;

      ticks(3);
      reset = 1'b0;
      ticks(1);
      chk("rst_miso", 32'(mcu_miso), 32'h0);
      chk("rst_empty", 32'(tx_empty), 32'h1);
      chk("rst_full", 32'(tx_full), 32'h0);
      chk("rst_level", 32'(tx_level), 32'h0);
      chk("rst_ovf", 32'(tx_ovf), 32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);

      // Single frame
      push({CMD_DEBUG + 8'hA2, 8'h3C, 8'h0F});   // 0xA53C0F
      chk("t1_level", 32'(tx_level), 32'h1);
      d0 = done_cnt;
      mcu_frame(24, 1'b0, 24'h0, rx);
      chk("t1_frame", 32'(rx), 32'hA53C0F);
      chk("t1_done", 32'(done_cnt - d0), 32'h1);
      chk("t1_empty", 32'(tx_empty), 32'h1);

      // Empty FIFO returns the idle frame without popping
      d0 = done_cnt;
      mcu_frame(24, 1'b0, 24'h0, rx);
      chk("t2_frame", 32'(rx), 32'h000000);
      chk("t2_done", 32'(done_cnt - d0), 32'h1);
      chk("t2_level", 32'(tx_level), 32'h0);

      // Overflow: fifth push into a depth-4 FIFO is dropped
      o0 = ovf_cnt;
      push({CMD_STATUS, 8'h10, 8'h11});
      push({CMD_CART_SIZE, 8'h20, 8'h21});
      push({CMD_DEBUG, 8'h30, 8'h31});
      push(24'h444444);
      push(24'h555555);
      chk("t3_ovf", 32'(ovf_cnt - o0), 32'h1);
      chk("t3_level", 32'(tx_level), 32'h4);
      chk("t3_full", 32'(tx_full), 32'h1);
      exp_q = '{24'h011011, 24'h022021, 24'h033031, 24'h444444};
      foreach (exp_q[k]) begin
         mcu_frame(24, 1'b0, 24'h0, rx);
         chk($sformatf("t3_frame%0d", k), 32'(rx), 32'(exp_q[k]));
      end
      chk("t3_empty", 32'(tx_empty), 32'h1);

      // Abort after 10 bits, head resent in full then popped
      push(24'h112233);
      d0 = done_cnt;
      mcu_frame(10, 1'b0, 24'h0, rx);
      chk("t4_partial", 32'(rx), 32'h112233 >> 14);
      chk("t4_level_abort", 32'(tx_level), 32'h1);
      chk("t4_no_done", 32'(done_cnt - d0), 32'h0);
      mcu_frame(24, 1'b0, 24'h0, rx);
      chk("t4_frame", 32'(rx), 32'h112233);
      chk("t4_level", 32'(tx_level), 32'h0);

      // Full FIFO, push coincident with the pop on the 24th SCK rise
      push(24'hF0F0F0);
      push(24'hF1F1F1);
      push(24'hF2F2F2);
      push(24'hF3F3F3);
      o0 = ovf_cnt;
      mcu_frame(24, 1'b1, 24'h777777, rx);
      chk("t5_frame", 32'(rx), 32'hF0F0F0);
      chk("t5_level", 32'(tx_level), 32'h4);
      chk("t5_full", 32'(tx_full), 32'h1);
      chk("t5_no_ovf", 32'(ovf_cnt - o0), 32'h0);
      exp_q = '{24'hF1F1F1, 24'hF2F2F2, 24'hF3F3F3, 24'h777777};
      foreach (exp_q[k]) begin
         mcu_frame(24, 1'b0, 24'h0, rx);
         chk($sformatf("t5_frame%0d", k), 32'(rx), 32'(exp_q[k]));
      end

      // Reset mid-frame at bit 12
      push(24'hABCDEF);
      push(24'h123456);
      mcu_ss = 1'b0;
      ticks(4);
      for (int b = 0; b < 12; b++) begin
         mcu_sck = 1'b1;
         ticks(4);
         mcu_sck = 1'b0;
         ticks(4);
      end
      reset = 1'b1;
      ticks(1);
      chk("t6_miso", 32'(mcu_miso), 32'h0);
      chk("t6_level", 32'(tx_level), 32'h0);
      chk("t6_empty", 32'(tx_empty), 32'h1);
      reset = 1'b0;
      mcu_ss = 1'b1;
      ticks(6);
      mcu_frame(24, 1'b0, 24'h0, rx);
      chk("t6_frame", 32'(rx), 32'h000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
